// File: rtl/hash_word_scanner.sv
// hash_word_scanner: captures a 256-bit digest and presents one 16-bit slice
// at a time, stepped by debounced buttons or by an auto-scroll timer.
module hash_word_scanner #(
  parameter logic [15:0] AUTO_TICKS     = 16'd500,
  parameter logic [7:0]  DEBOUNCE_TICKS = 8'd20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [255:0] digest,
  input  logic         digest_valid,
  output logic         digest_ready,
  input  logic         hold,
  input  logic         btn_next,
  input  logic         btn_prev,
  input  logic         auto_en,
  output logic [15:0]  word_out,
  output logic [3:0]   word_idx,
  output logic         loaded
);

  typedef enum logic [1:0] {EMPTY, MANUAL, AUTO} state_t;

  state_t       state_q, state_d;
  logic [255:0] digest_q;
  logic [3:0]   idx_q, idx_d;
  logic [15:0]  acnt_q, acnt_d;

  // Button bit 0 = next, bit 1 = prev
  logic [1:0]   sync1_q, sync2_q;
  logic [1:0]   deb_q, deb_dly_q;
  logic [7:0]   dcnt_next_q, dcnt_prev_q;
  logic [8:0]   dbn_next, dbn_prev;
  logic [1:0]   step;
  logic         capture;

  // One debounce step: returns {new level, new count}. A tick where the
  // synchronized level matches the debounced one restarts the count.
  function automatic logic [8:0] debounce_next(input logic       sync,
                                               input logic       deb,
                                               input logic [7:0] cnt);
    if (sync == deb)
      return {deb, 8'd0};
    else if (cnt == DEBOUNCE_TICKS - 8'd1)
      return {sync, 8'd0};
    else
      return {deb, cnt + 8'd1};
  endfunction

  assign digest_ready = ~hold;
  assign capture      = digest_valid & digest_ready;
  assign step         = deb_q & ~deb_dly_q;
  assign loaded       = (state_q != EMPTY);
  assign word_idx     = idx_q;
  assign word_out     = loaded ? digest_q[{idx_q, 4'b0000} +: 16] : '0;

  // Next debounce values for both buttons
  always_comb begin
    dbn_next = debounce_next(sync2_q[0], deb_q[0], dcnt_next_q);
    dbn_prev = debounce_next(sync2_q[1], deb_q[1], dcnt_prev_q);
  end

  // Synchronizers, debounce counters and debounced levels
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      dcnt_next_q <= '0;
      dcnt_prev_q <= '0;
    end else begin
      sync1_q   <= {btn_prev, btn_next};
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      if (tick) begin
        deb_q       <= {dbn_prev[8], dbn_next[8]};
        dcnt_next_q <= dbn_next[7:0];
        dcnt_prev_q <= dbn_prev[7:0];
      end
    end
  end

  // Mode, index and auto-scroll counter next-state; capture beats steps,
  // and any step pulse beats (and clears) the auto-advance timer
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acnt_d  = acnt_q;
    case (state_q)
      EMPTY:        if (capture) state_d = auto_en ? AUTO : MANUAL;
      MANUAL, AUTO: state_d = auto_en ? AUTO : MANUAL;
      default:      state_d = EMPTY;
    endcase
    if (capture) begin
      idx_d  = '0;
      acnt_d = '0;
    end else if (state_q != EMPTY) begin
      if (|step) begin
        if (step[0] & ~step[1])
          idx_d = idx_q + 4'd1;
        else if (step[1] & ~step[0])
          idx_d = idx_q - 4'd1;
        acnt_d = '0;
      end else if (state_q == AUTO) begin
        if (tick) begin
          if (acnt_q == AUTO_TICKS - 16'd1) begin
            acnt_d = '0;
            idx_d  = idx_q + 4'd1;
          end else begin
            acnt_d = acnt_q + 16'd1;
          end
        end
      end else begin
        acnt_d = '0;
      end
    end
  end

  // State, index, counter and captured digest registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      acnt_q   <= '0;
      digest_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acnt_q  <= acnt_d;
      if (capture) digest_q <= digest;
    end
  end

endmodule

// File: doc/hash_word_scanner.md
HASH_WORD_SCANNER -- requirements
Module: hash_word_scanner

Interface
REQ-001 Parameter: AUTO_TICKS, default 16'd500, number of tick strobes between auto-advances (legal 1..65535).
REQ-002 Parameter: DEBOUNCE_TICKS, default 8'd20, number of consecutive tick strobes a button must be stable to register (legal 1..255).
REQ-003 The block SHALL have one clock and a synchronous active-high reset:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  single-cycle enable strobe (slow timebase); all debounce and auto timing counts only on tick=1.
- digest  in  256  hash result from the upstream hash core.
- digest_valid  in  1  upstream asserts when digest is stable.
- digest_ready  out  1  block can accept a digest.
- hold  in  1  freeze: block refuses new digests while high.
- btn_next  in  1  raw asynchronous button, step forward.
- btn_prev  in  1  raw asynchronous button, step back.
- auto_en  in  1  level; 1 selects auto-scroll mode.
- word_out  out  16  selected 16-bit slice of the captured digest, feeds the 7-segment driver digits.
- word_idx  out  4  index of the displayed slice.
- loaded  out  1  a digest has been captured since reset.

Function
REQ-004 Handshake: capture SHALL occur on a rising clk edge with digest_valid=1 and digest_ready=1; digest_ready = ~hold, combinational.
REQ-005 On capture: digest register <= digest, word_idx <= 0, auto counter <= 0, loaded <= 1; word_out SHALL show digest[15:0] on the cycle after capture.
REQ-006 word_out SHALL equal captured[16*word_idx +: 16] (slice 0 = bits 15:0, slice 15 = bits 255:240); 16'h0000 while loaded=0.
REQ-007 FSM states EMPTY, MANUAL, AUTO; EMPTY -> MANUAL/AUTO on capture per auto_en; MANUAL <-> AUTO follows auto_en one cycle after it changes; only reset returns to EMPTY.
REQ-008 Buttons SHALL pass through a 2-flop synchronizer, then a debouncer: debounced level updates only after the synchronized level differs from it for DEBOUNCE_TICKS consecutive tick strobes; any bounce restarts the count.
REQ-009 A 0->1 transition of a debounced level SHALL produce exactly one step pulse; held buttons produce no further steps.
REQ-010 Step next: word_idx increments, 15 wraps to 0; step prev: decrements, 0 wraps to 15.
REQ-011 Simultaneous next and prev step pulses in the same cycle SHALL leave word_idx unchanged.
REQ-012 In AUTO, a 16-bit counter SHALL increment per tick; on reaching AUTO_TICKS it clears and word_idx advances by 1 (wrapping).
REQ-013 Manual step in AUTO SHALL take effect, and the auto counter SHALL clear in the same cycle; a coincident auto-advance is discarded.
REQ-014 Capture SHALL take priority over any step or auto-advance in the same cycle.
REQ-015 In EMPTY, steps and auto-advance SHALL be ignored; word_idx stays 0.
REQ-016 Entering MANUAL from AUTO SHALL freeze word_idx and clear the auto counter.

Reset
REQ-017 On rst=1 at a clk edge: state EMPTY, word_idx=0, word_out=16'h0000, loaded=0, digest register, debounce counters, synchronizers, debounced levels, and auto counter = 0.
REQ-018 rst SHALL override capture, steps, and auto-advance in the same cycle; reset mid-scroll discards the held digest.
REQ-019 digest_ready SHALL still follow ~hold during and after reset.

Verification
REQ-020 Capture: digest = 256'h0123...ABCDEF with valid=1, hold=0 -> next cycle loaded=1, word_idx=0, word_out=digest[15:0]; with hold=1, valid=1 -> no capture, ready=0.
REQ-021 Wrap: DEBOUNCE_TICKS=2, auto_en=0, one clean btn_prev press at idx 0 -> word_idx=15, word_out=digest[255:240]; 16 btn_next presses -> word_idx returns to start.
REQ-022 Bounce: btn_next toggles every tick for 10 ticks, then stays high for 20 ticks -> exactly one increment.
REQ-023 Auto: AUTO_TICKS=3, auto_en=1 -> word_idx advances every 3rd tick, 15->0 wrap; btn_next press on an advance tick -> single +1, counter cleared.
REQ-024 Priority/reset: capture coincident with auto-advance -> word_idx=0; rst asserted mid-scroll at idx 9 -> next cycle word_idx=0, word_out=0, loaded=0.
